m68k_bus_master: RTL and testbench



---
 rtl/m68k_bus_master.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_m68k_bus_master.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/m68k_bus_master.sv
// 68000-style bus initiator: runs one DTACK (asynchronous) or VPA/VMA/E (6800-synchronous) cycle per host request.
// Optional `define BUS_TIMEOUT_EN adds a wait-state watchdog limited to TIMEOUT_CYCLES clocks in S4/VPA.
module m68k_bus_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        C7M,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [22:0] REQ_A,
    input  logic        REQ_UDS,
    input  logic        REQ_LDS,
    input  logic [15:0] REQ_WD,
    output logic        BUSY,
    output logic        ACK,
    output logic        ERR,
    output logic [15:0] RD,
    output logic [22:0] A,
    output logic        PRnW,
    output logic        nAS,
    output logic        nUDS,
    output logic        nLDS,
    output logic        BUS_OE,
    output logic        D_OE,
    output logic [15:0] D_OUT,
    input  logic [15:0] D_IN,
    input  logic        nDTACK,
    input  logic        nVPA,
    input  logic        nBERR,
    output logic        E,
    output logic        nVMA
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S0   = 3'd1,
        S2   = 3'd2,
        S4   = 3'd3,
        VPA  = 3'd4,
        S6   = 3'd5,
        S7   = 3'd6
    } state_t;

    state_t      state_r, stateNext_s;
    logic [3:0]  eCnt_r, eCntNext_s;
    logic        e_r, eNext_s;
    logic        busy_r, busyNext_s;
    logic        ack_r, ackNext_s;
    logic        err_r, errNext_s;
    logic [15:0] rd_r, rdNext_s;
    logic [22:0] a_r, aNext_s;
    logic        prnw_r, prnwNext_s;
    logic        nAs_r, nAsNext_s;
    logic        nUds_r, nUdsNext_s;
    logic        nLds_r, nLdsNext_s;
    logic        nVma_r, nVmaNext_s;
    logic        busOe_r, busOeNext_s;
    logic        dOe_r, dOeNext_s;
    logic [15:0] dOut_r, dOutNext_s;
    logic        reqRw_r, reqRwNext_s;
    logic        reqUds_r, reqUdsNext_s;
    logic        reqLds_r, reqLdsNext_s;
    logic [15:0] reqWd_r, reqWdNext_s;
    logic        timeoutHit_s;

`ifdef BUS_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 32'sd255) ? $clog2(TIMEOUT_CYCLES + 32'sd1) : 32'sd8;

    logic [TMO_W-1:0] tmoCnt_r, tmoCntNext_s;

    // Watchdog count: zeroed on the edge entering S4, advanced on every clock spent in S4 or VPA
    always_comb begin
        tmoCntNext_s = tmoCnt_r;
        if (state_r == S2) begin
            tmoCntNext_s = '0;
        end else if ((state_r == S4) || (state_r == VPA)) begin
            tmoCntNext_s = tmoCnt_r + TMO_W'(1);
        end else begin
            tmoCntNext_s = tmoCnt_r;
        end
    end

    // Watchdog register
    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            tmoCnt_r <= '0;
        end else begin
            tmoCnt_r <= tmoCntNext_s;
        end
    end

    // True on the TIMEOUT_CYCLES-th clock leaving S4/VPA
    assign timeoutHit_s = (tmoCnt_r == TMO_W'(TIMEOUT_CYCLES - 32'sd1));
`else
    assign timeoutHit_s = 1'b0;
`endif

    // E clock divider: ECNT runs 0..9, E high for counts 6..9
    always_comb begin
        if (eCnt_r == 4'd9) begin
            eCntNext_s = 4'd0;
        end else begin
            eCntNext_s = eCnt_r + 4'd1;
        end
        eNext_s = (eCntNext_s >= 4'd6);
    end

    // Next-state and registered-output values; each state's outputs appear on the edge that enters it
    always_comb begin
        stateNext_s  = state_r;
        busyNext_s   = busy_r;
        errNext_s    = 1'b0;
        rdNext_s     = rd_r;
        aNext_s      = a_r;
        prnwNext_s   = prnw_r;
        nAsNext_s    = nAs_r;
        nUdsNext_s   = nUds_r;
        nLdsNext_s   = nLds_r;
        nVmaNext_s   = nVma_r;
        busOeNext_s  = busOe_r;
        dOeNext_s    = dOe_r;
        dOutNext_s   = dOut_r;
        reqRwNext_s  = reqRw_r;
        reqUdsNext_s = reqUds_r;
        reqLdsNext_s = reqLds_r;
        reqWdNext_s  = reqWd_r;

        case (state_r)
            IDLE: begin
                if (REQ) begin
                    busyNext_s   = 1'b1;
                    reqRwNext_s  = REQ_RW;
                    reqUdsNext_s = REQ_UDS;
                    reqLdsNext_s = REQ_LDS;
                    reqWdNext_s  = REQ_WD;
                    // A request with no byte enables completes as an error without touching the bus
                    if (!REQ_UDS && !REQ_LDS) begin
                        stateNext_s = S7;
                        errNext_s   = 1'b1;
                    end else begin
                        stateNext_s = S0;
                        busOeNext_s = 1'b1;
                        aNext_s     = REQ_A;
                        prnwNext_s  = REQ_RW;
                        nAsNext_s   = 1'b1;
                    end
                end else begin
                    stateNext_s = IDLE;
                end
            end
            S0: begin
                stateNext_s = S2;
                nAsNext_s   = 1'b0;
                if (reqRw_r) begin
                    nUdsNext_s = ~reqUds_r;
                    nLdsNext_s = ~reqLds_r;
                end else begin
                    dOeNext_s  = 1'b1;
                    dOutNext_s = reqWd_r;
                end
            end
            S2: begin
                // Reads already have their strobes; writes assert them one clock later, after data settles
                stateNext_s = S4;
                nUdsNext_s  = ~reqUds_r;
                nLdsNext_s  = ~reqLds_r;
            end
            S4: begin
                if (!nBERR) begin
                    stateNext_s = S7;
                    errNext_s   = 1'b1;
                end else if (!nDTACK) begin
                    stateNext_s = S6;
                end else if (!nVPA) begin
                    stateNext_s = VPA;
                end else if (timeoutHit_s) begin
                    stateNext_s = S7;
                    errNext_s   = 1'b1;
                end else begin
                    stateNext_s = S4;
                end
            end
            S6: begin
                stateNext_s = S7;
                if (reqRw_r) begin
                    rdNext_s = D_IN;
                end else begin
                    rdNext_s = rd_r;
                end
            end
            VPA: begin
                if (eCnt_r == 4'd3) begin
                    nVmaNext_s = 1'b0;
                end else begin
                    nVmaNext_s = nVma_r;
                end
                // Termination lines up with the falling edge of E
                if ((eCnt_r == 4'd9) && !nVma_r) begin
                    stateNext_s = S7;
                    if (reqRw_r) begin
                        rdNext_s = D_IN;
                    end else begin
                        rdNext_s = rd_r;
                    end
                end else if (timeoutHit_s) begin
                    stateNext_s = S7;
                    errNext_s   = 1'b1;
                end else begin
                    stateNext_s = VPA;
                end
            end
            S7: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
                busOeNext_s = 1'b0;
                dOeNext_s   = 1'b0;
                prnwNext_s  = 1'b1;
            end
            default: begin
                stateNext_s = IDLE;
                busyNext_s  = 1'b0;
                busOeNext_s = 1'b0;
                dOeNext_s   = 1'b0;
                prnwNext_s  = 1'b1;
                nAsNext_s   = 1'b1;
                nUdsNext_s  = 1'b1;
                nLdsNext_s  = 1'b1;
                nVmaNext_s  = 1'b1;
            end
        endcase

        if (stateNext_s == S7) begin
            ackNext_s  = 1'b1;
            nAsNext_s  = 1'b1;
            nUdsNext_s = 1'b1;
            nLdsNext_s = 1'b1;
            nVmaNext_s = 1'b1;
        end else begin
            ackNext_s  = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge C7M or posedge RESET) begin
        if (RESET) begin
            state_r  <= IDLE;
            eCnt_r   <= 4'd0;
            e_r      <= 1'b0;
            busy_r   <= 1'b0;
            ack_r    <= 1'b0;
            err_r    <= 1'b0;
            rd_r     <= 16'h0000;
            a_r      <= 23'h000000;
            prnw_r   <= 1'b1;
            nAs_r    <= 1'b1;
            nUds_r   <= 1'b1;
            nLds_r   <= 1'b1;
            nVma_r   <= 1'b1;
            busOe_r  <= 1'b0;
            dOe_r    <= 1'b0;
            dOut_r   <= 16'h0000;
            reqRw_r  <= 1'b1;
            reqUds_r <= 1'b0;
            reqLds_r <= 1'b0;
            reqWd_r  <= 16'h0000;
        end else begin
            state_r  <= stateNext_s;
            eCnt_r   <= eCntNext_s;
            e_r      <= eNext_s;
            busy_r   <= busyNext_s;
            ack_r    <= ackNext_s;
            err_r    <= errNext_s;
            rd_r     <= rdNext_s;
            a_r      <= aNext_s;
            prnw_r   <= prnwNext_s;
            nAs_r    <= nAsNext_s;
            nUds_r   <= nUdsNext_s;
            nLds_r   <= nLdsNext_s;
            nVma_r   <= nVmaNext_s;
            busOe_r  <= busOeNext_s;
            dOe_r    <= dOeNext_s;
            dOut_r   <= dOutNext_s;
            reqRw_r  <= reqRwNext_s;
            reqUds_r <= reqUdsNext_s;
            reqLds_r <= reqLdsNext_s;
            reqWd_r  <= reqWdNext_s;
        end
    end

    assign BUSY   = busy_r;
    assign ACK    = ack_r;
    assign ERR    = err_r;
    assign RD     = rd_r;
    assign A      = a_r;
    assign PRnW   = prnw_r;
    assign nAS    = nAs_r;
    assign nUDS   = nUds_r;
    assign nLDS   = nLds_r;
    assign nVMA   = nVma_r;
    assign BUS_OE = busOe_r;
    assign D_OE   = dOe_r;
    assign D_OUT  = dOut_r;
    assign E      = e_r;

endmodule

// File: tb/tb_m68k_bus_master.sv
// Directed bench for m68k_bus_master: DTACK read/write, VPA cycle, bus error, null request, reset abort,
// and the BUS_TIMEOUT_EN watchdog (DUT built with TIMEOUT_CYCLES=16 when that macro is defined).
module tb_m68k_bus_master;

`ifdef BUS_TIMEOUT_EN
    localparam int TB_TMO = 16;
`else
    localparam int TB_TMO = 255;
`endif

    logic        C7M, RESET, REQ, REQ_RW, REQ_UDS, REQ_LDS;
    logic [22:0] REQ_A, A;
    logic [15:0] REQ_WD, RD, D_OUT, D_IN;
    logic        BUSY, ACK, ERR, PRnW, nAS, nUDS, nLDS, BUS_OE, D_OE;
    logic        nDTACK, nVPA, nBERR, E, nVMA;

    int checkCnt = 0;
    int passCnt  = 0;

    // results of the last run_req
    int   ackAt, nAsLow, nUdsLow, nLdsLow, vmaFallEcnt;
    logic errAtAck, eAtAck, ePrevAtAck, busOeSeen;
    logic [3:0] ecntM;
    int   ackCount;

    m68k_bus_master #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .C7M(C7M), .RESET(RESET), .REQ(REQ), .REQ_RW(REQ_RW), .REQ_A(REQ_A),
        .REQ_UDS(REQ_UDS), .REQ_LDS(REQ_LDS), .REQ_WD(REQ_WD), .BUSY(BUSY), .ACK(ACK),
        .ERR(ERR), .RD(RD), .A(A), .PRnW(PRnW), .nAS(nAS), .nUDS(nUDS), .nLDS(nLDS),
        .BUS_OE(BUS_OE), .D_OE(D_OE), .D_OUT(D_OUT), .D_IN(D_IN), .nDTACK(nDTACK),
        .nVPA(nVPA), .nBERR(nBERR), .E(E), .nVMA(nVMA)
    );

    initial C7M = 1'b0;
    always #5 C7M = ~C7M;

    // Reference E-divider count, expected to track the DUT's ECNT from reset release
    always @(posedge C7M or posedge RESET) begin
        if (RESET) ecntM <= 4'd0;
        else if (ecntM == 4'd9) ecntM <= 4'd0;
        else ecntM <= ecntM + 4'd1;
    end

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) passCnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    // Posts one request at the current negedge; index i = posedges since REQ was raised (sampling edge = 1).
    // Bus responses go low at the negedge after edge dtackAt/berrAt/vpaAt (0 = never).
    task automatic run_req(input logic rw, input logic [22:0] addr, input logic uds, input logic lds,
                           input logic [15:0] wd, input int dtackAt, input int berrAt, input int vpaAt,
                           input int maxCyc);
        logic ePrev;
        REQ_RW = rw; REQ_A = addr; REQ_UDS = uds; REQ_LDS = lds; REQ_WD = wd; REQ = 1'b1;
        ackAt = -1; nAsLow = 0; nUdsLow = 0; nLdsLow = 0; vmaFallEcnt = -1;
        errAtAck = 1'b0; eAtAck = 1'b0; ePrevAtAck = 1'b0; busOeSeen = 1'b0;
        ePrev = E;
        for (int i = 1; i <= maxCyc; i++) begin
            @(negedge C7M);
            REQ = 1'b0;
            if (!nAS) nAsLow++;
            if (!nUDS) nUdsLow++;
            if (!nLDS) nLdsLow++;
            if (BUS_OE) busOeSeen = 1'b1;
            if (!nVMA && vmaFallEcnt < 0) vmaFallEcnt = 32'(ecntM);
            if (ACK) begin
                ackAt = i; errAtAck = ERR; eAtAck = E; ePrevAtAck = ePrev;
                break;
            end
            ePrev = E;
            if (i == dtackAt) nDTACK = 1'b0;
            if (i == berrAt) nBERR = 1'b0;
            if (i == vpaAt) nVPA = 1'b0;
        end
        nDTACK = 1'b1; nBERR = 1'b1; nVPA = 1'b1;
    endtask

    task automatic after_ack(input string tag);
        @(negedge C7M);
        check_value({tag, "_busy_clr"}, 32'(BUSY), 32'd0);
        check_value({tag, "_oe_clr"}, 32'({BUS_OE, D_OE, ACK}), 32'd0);
    endtask

    initial begin
        RESET = 1'b1; REQ = 1'b0; REQ_RW = 1'b1; REQ_A = 23'h000000; REQ_UDS = 1'b0; REQ_LDS = 1'b0;
        REQ_WD = 16'h0000; D_IN = 16'h0000; nDTACK = 1'b1; nVPA = 1'b1; nBERR = 1'b1;
        repeat (2) @(negedge C7M);
        check_value("rst_strobes", 32'({nAS, nUDS, nLDS, nVMA, PRnW}), 32'h1F);
        check_value("rst_ctrl", 32'({BUS_OE, D_OE, ACK, ERR, BUSY, E}), 32'h00);
        check_value("rst_a_rd", {A[15:0], RD}, 32'h0000_0000);
        RESET = 1'b0;
        @(negedge C7M);

        // 1: zero-wait DTACK read
        D_IN = 16'h1234;
        run_req(1'b1, 23'h07C000, 1'b1, 1'b1, 16'h0000, 2, 0, 0, 20);
        check_value("t1_ack_at", 32'(ackAt), 32'd5);
        check_value("t1_err", 32'(errAtAck), 32'd0);
        check_value("t1_nas_low", 32'(nAsLow), 32'd3);
        check_value("t1_ds_low", 32'(nUdsLow + nLdsLow), 32'd6);
        check_value("t1_rd", 32'(RD), 32'h1234);
        check_value("t1_addr", 32'(A), 32'h07C000);
        after_ack("t1");

        // 2: lower-byte write with 3 wait states
        D_IN = 16'hFFFF;
        run_req(1'b0, 23'h000100, 1'b0, 1'b1, 16'h00AB, 6, 0, 0, 20);
        check_value("t2_ack_at", 32'(ackAt), 32'd8);
        check_value("t2_nuds_low", 32'(nUdsLow), 32'd0);
        check_value("t2_nlds_low", 32'(nLdsLow), 32'd5);
        check_value("t2_dout", 32'(D_OUT), 32'h00AB);
        check_value("t2_doe_prnw", 32'({D_OE, PRnW}), 32'b10);
        check_value("t2_rd_kept", 32'(RD), 32'h1234);
        after_ack("t2");

        // 3: 6800 synchronous read through VPA
        D_IN = 16'hC1A5;
        run_req(1'b1, 23'h5FE800, 1'b1, 1'b1, 16'h0000, 0, 0, 2, 40);
        check_value("t3_acked", 32'(ackAt > 0), 32'd1);
        check_value("t3_vma_ecnt", 32'(vmaFallEcnt), 32'd4);
        check_value("t3_e_fall", 32'({ePrevAtAck, eAtAck}), 32'b10);
        check_value("t3_ecnt_ack", 32'(ecntM), 32'd0);
        check_value("t3_rd", 32'(RD), 32'hC1A5);
        after_ack("t3");
        check_value("e_vs_ecnt", 32'(E), 32'(ecntM >= 4'd6));

        // 4: BERR wins over DTACK; then a request with no byte enables
        D_IN = 16'hDEAD;
        run_req(1'b1, 23'h000200, 1'b1, 1'b1, 16'h0000, 3, 3, 0, 20);
        check_value("t4_ack_at", 32'(ackAt), 32'd4);
        check_value("t4_err", 32'(errAtAck), 32'd1);
        check_value("t4_rd_kept", 32'(RD), 32'hC1A5);
        after_ack("t4");
        run_req(1'b1, 23'h000300, 1'b0, 1'b0, 16'h0000, 0, 0, 0, 10);
        check_value("t4n_ack_at", 32'(ackAt), 32'd1);
        check_value("t4n_err", 32'(errAtAck), 32'd1);
        check_value("t4n_no_bus", 32'({nAsLow != 0, busOeSeen}), 32'd0);
        after_ack("t4n");

        // 5: asynchronous reset while waiting in S4
        run_req(1'b1, 23'h000400, 1'b1, 1'b1, 16'h0000, 0, 0, 0, 3);
        check_value("t5_in_s4", 32'({nAS, BUS_OE}), 32'b01);
        RESET = 1'b1;
        #1;
        check_value("t5_rst_strobes", 32'({nAS, nUDS, nLDS, nVMA}), 32'hF);
        check_value("t5_rst_ctrl", 32'({BUS_OE, BUSY, ACK}), 32'd0);
        @(negedge C7M);
        RESET = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge C7M);
            if (ACK) ackCount++;
        end
        check_value("t5_no_ack", 32'(ackCount), 32'd0);
        check_value("t5_rd_rst", 32'(RD), 32'h0000);

        // 5b: no response at all
        D_IN = 16'h5555;
        run_req(1'b1, 23'h000500, 1'b1, 1'b1, 16'h0000, 0, 0, 0, 40);
`ifdef BUS_TIMEOUT_EN
        check_value("t5b_tmo_ack_at", 32'(ackAt), 32'd19);
        check_value("t5b_tmo_err", 32'(errAtAck), 32'd1);
        check_value("t5b_rd_kept", 32'(RD), 32'h0000);
`else
        check_value("t5b_still_waiting", 32'(ackAt), 32'hFFFF_FFFF);
        check_value("t5b_busy", 32'({BUSY, nAS}), 32'b10);
        nDTACK = 1'b0;
        ackCount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge C7M);
            if (ACK) begin
                ackCount = 1;
                break;
            end
        end
        nDTACK = 1'b1;
        check_value("t5b_late_ack", 32'(ackCount), 32'd1);
        check_value("t5b_late_rd", 32'(RD), 32'h5555);
`endif
        after_ack("t5b");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
